// File: rtl/ram_pkg.sv
// Shared definitions for the 1024x32 block RAM and every client that talks to it.
package ram_pkg;

  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DATA_W = 32;

  localparam logic [3:0] CTRL_IDLE = 4'b0001;
  localparam logic [3:0] CTRL_WR   = 4'b0010;
  localparam logic [3:0] CTRL_RD   = 4'b0100;
  localparam logic [3:0] CTRL_RESP = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE = CTRL_IDLE,
    ST_WR   = CTRL_WR,
    ST_RD   = CTRL_RD,
    ST_RESP = CTRL_RESP
  } ctrl_state_e;

endpackage

// File: rtl/bram_port_ctrl.sv
// Single-port BRAM access controller: one request at a time, counts out the
// BRAM read latency and returns read data over a valid/ready channel.
module bram_port_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout
);

  // Latency is at most 7, so a 3-bit counter reaches every legal target.
  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  ctrl_state_e       state_q;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_din_q;
  logic              bram_we_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;

  // Ready only in IDLE and never while reset is asserted; independent of req_valid.
  assign req_ready = (state_q == ST_IDLE) && rstn;

  assign bram_addr  = bram_addr_q;
  assign bram_din   = bram_din_q;
  assign bram_we    = bram_we_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

  // Request FSM, latency counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bram_addr_q  <= '0;
      bram_din_q   <= '0;
      bram_we_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            bram_addr_q <= req_addr;
            if (req_we) begin
              bram_din_q <= req_wdata;
              bram_we_q  <= 1'b1;
              state_q    <= ST_WR;
            end else begin
              bram_we_q <= 1'b0;
              cnt_q     <= '0;
              state_q   <= ST_RD;
            end
          end
        end
        ST_WR: begin
          bram_we_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        ST_RD: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == RD_LAT_C) begin
            resp_rdata_q <= bram_dout;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          bram_we_q    <= 1'b0;
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Bench for bram_port_ctrl: three controllers (read latency 2, 1 and 7), each
// with its own behavioural BRAM, plus a transaction-level model of the latency-2 one.
module tb_bram_port_ctrl;

  localparam int AW        = 10;
  localparam int DW        = 32;
  localparam int MODEL_LAT = 2;
  localparam int FOREVER_C = 1 << 30;

  logic clk = 1'b0;
  logic rstn;
  int   cycleCount = 0;
  int   total = 0;
  int   bad = 0;
  int   weCount = 0;

  logic          reqValid  [3];
  logic          reqWe     [3];
  logic [AW-1:0] reqAddr   [3];
  logic [DW-1:0] reqWdata  [3];
  logic          respReady [3];
  logic          reqReady  [3];
  logic          respValid [3];
  logic [DW-1:0] respRdata [3];
  logic [AW-1:0] bramAddr  [3];
  logic [DW-1:0] bramDin   [3];
  logic          bramWe    [3];
  logic [DW-1:0] bramDout  [3];

  // Free-running clock and a cycle index used for all timing expectations.
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount++;

  // Count write-enable pulses on the main controller.
  always @(negedge clk) if (bramWe[0] === 1'b1) weCount++;

  // One controller plus a behavioural read-first BRAM per latency under test.
  for (genvar k = 0; k < 3; k++) begin : g_inst
    localparam int LAT = (k == 0) ? 2 : ((k == 1) ? 1 : 7);
    logic [DW-1:0] mem  [0:(1<<AW)-1];
    logic [DW-1:0] pipe [0:LAT-1];

    initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
    end

    always @(posedge clk) begin
      if (bramWe[k]) mem[bramAddr[k]] <= bramDin[k];
      pipe[0] <= mem[bramAddr[k]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign bramDout[k] = pipe[LAT-1];

    bram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (reqValid[k]),
      .req_ready  (reqReady[k]),
      .req_we     (reqWe[k]),
      .req_addr   (reqAddr[k]),
      .req_wdata  (reqWdata[k]),
      .resp_valid (respValid[k]),
      .resp_ready (respReady[k]),
      .resp_rdata (respRdata[k]),
      .bram_addr  (bramAddr[k]),
      .bram_din   (bramDin[k]),
      .bram_we    (bramWe[k]),
      .bram_dout  (bramDout[k])
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h want %h", name, cycleCount, act, exp);
    end
  endtask

  // Transaction-level model: a word array plus the cycle numbers at which
  // each accepted request must become visible on the outputs.
  logic [DW-1:0] modelMem [0:(1<<AW)-1];
  bit            modelOn = 0;
  int            busyUntil, weCycle, respFrom;
  bit            respPending;
  logic [DW-1:0] respData, lastRdata, lastDin;
  logic [AW-1:0] lastAddr;

  initial for (int i = 0; i < (1 << AW); i++) modelMem[i] = '0;

  // Compare the latency-2 controller against the model every cycle.
  always @(negedge clk) begin
    int            c;
    logic          expReady, expValid;
    logic [DW-1:0] expRdata;
    c = cycleCount;
    if (modelOn) begin
      expReady = rstn && (c >= busyUntil) && !respPending;
      expValid = respPending && (c >= respFrom);
      expRdata = expValid ? respData : lastRdata;
      checkOutput("req_ready",  32'(reqReady[0]),  32'(expReady));
      checkOutput("bram_we",    32'(bramWe[0]),    32'(c == weCycle));
      checkOutput("bram_addr",  32'(bramAddr[0]),  32'(lastAddr));
      checkOutput("bram_din",   bramDin[0],        lastDin);
      checkOutput("resp_valid", 32'(respValid[0]), 32'(expValid));
      checkOutput("resp_rdata", respRdata[0],      expRdata);
      if (rstn) begin
        if (expValid && respReady[0]) begin
          respPending = 0;
          lastRdata   = respData;
          busyUntil   = c + 1;
        end
        if (expReady && reqValid[0]) begin
          lastAddr = reqAddr[0];
          if (reqWe[0]) begin
            modelMem[reqAddr[0]] = reqWdata[0];
            lastDin   = reqWdata[0];
            weCycle   = c + 1;
            busyUntil = c + 2;
          end else begin
            respPending = 1;
            respFrom    = c + 2 + MODEL_LAT;
            respData    = modelMem[reqAddr[0]];
            busyUntil   = FOREVER_C;
          end
        end
      end
    end
    if (rstn === 1'b0) begin
      modelOn     = 1;
      busyUntil   = c + 1;
      respPending = 0;
      weCycle     = -1;
      respFrom    = FOREVER_C;
      lastAddr    = '0;
      lastDin     = '0;
      lastRdata   = '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the handshake cycle; returns that cycle.
  task automatic issue(input int k, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input bit keep, output int hs);
    reqValid[k] = 1'b1;
    reqWe[k]    = we;
    reqAddr[k]  = addr;
    reqWdata[k] = data;
    hs = -1;
    for (int i = 0; i < 60 && hs < 0; i++) begin
      @(negedge clk);
      if (reqReady[k]) hs = cycleCount;
      tick();
    end
    if (hs < 0) checkOutput("issue_timeout", 32'd0, 32'd1);
    if (!keep) reqValid[k] = 1'b0;
  endtask

  // Wait for the first cycle with resp_valid high; returns that cycle and the data.
  task automatic waitResp(input int k, output logic [DW-1:0] d, output int cyc);
    cyc = -1;
    d   = '0;
    for (int i = 0; i < 60 && cyc < 0; i++) begin
      @(negedge clk);
      if (respValid[k]) begin
        cyc = cycleCount;
        d   = respRdata[k];
      end
      tick();
    end
    if (cyc < 0) checkOutput("resp_timeout", 32'd0, 32'd1);
  endtask

  // Random requests, backpressure and occasional resets on the main controller.
  task automatic applyStimulus(input int n);
    bit hs;
    for (int i = 0; i < n; i++) begin
      if (!reqValid[0] && $urandom_range(1, 0) == 1) begin
        reqValid[0] = 1'b1;
        reqWe[0]    = 1'($urandom_range(1, 0));
        reqAddr[0]  = 10'($urandom_range(7, 0));
        reqWdata[0] = $urandom;
      end
      respReady[0] = ($urandom_range(2, 0) != 0);
      rstn         = ($urandom_range(59, 0) != 0);
      @(negedge clk);
      hs = reqValid[0] && reqReady[0];
      tick();
      if (hs) reqValid[0] = 1'b0;
    end
    rstn         = 1'b1;
    reqValid[0]  = 1'b0;
    respReady[0] = 1'b1;
    repeat (12) tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int            hs, u, cyc, prev, weBase;
    logic [DW-1:0] d;
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      reqValid[k]  = 1'b0;
      reqWe[k]     = 1'b0;
      reqAddr[k]   = '0;
      reqWdata[k]  = '0;
      respReady[k] = 1'b1;
    end
    reqValid[0] = 1'b1;
    reqWe[0]    = 1'b1;

    // Reset held three cycles with a request pending.
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("rst_req_ready",  32'(reqReady[0]),  32'd0);
      checkOutput("rst_bram_we",    32'(bramWe[0]),    32'd0);
      checkOutput("rst_resp_valid", 32'(respValid[0]), 32'd0);
      checkOutput("rst_bram_addr",  32'(bramAddr[0]),  32'd0);
      checkOutput("rst_resp_rdata", respRdata[0],      32'd0);
      tick();
    end
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(reqReady[0]), 32'd1);
    tick();
    reqValid[0] = 1'b0;

    // Write then read address 0.
    issue(0, 1'b1, 10'h000, 32'h20, 1'b0, hs);
    @(negedge clk);
    checkOutput("wr_we_t1",   32'(bramWe[0]),   32'd1);
    checkOutput("wr_addr_t1", 32'(bramAddr[0]), 32'd0);
    checkOutput("wr_din_t1",  bramDin[0],       32'h20);
    tick();
    @(negedge clk);
    checkOutput("wr_ready_t2", 32'(reqReady[0]), 32'd1);
    checkOutput("wr_we_t2",    32'(bramWe[0]),   32'd0);
    tick();
    issue(0, 1'b0, 10'h000, 32'h0, 1'b0, u);
    waitResp(0, d, cyc);
    checkOutput("rd_latency", 32'(cyc - u), 32'd4);
    checkOutput("rd_data",    d,            32'h20);

    // Response backpressure with a second request held pending.
    issue(0, 1'b1, 10'h3FF, 32'hDEADBEEF, 1'b0, hs);
    respReady[0] = 1'b0;
    issue(0, 1'b0, 10'h3FF, 32'h0, 1'b0, u);
    waitResp(0, d, cyc);
    checkOutput("bp_data", d, 32'hDEADBEEF);
    reqValid[0] = 1'b1;
    reqWe[0]    = 1'b0;
    reqAddr[0]  = 10'h001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", 32'(respValid[0]), 32'd1);
      checkOutput("bp_hold_data",  respRdata[0],      32'hDEADBEEF);
      checkOutput("bp_hold_ready", 32'(reqReady[0]),  32'd0);
      tick();
    end
    respReady[0] = 1'b1;
    @(negedge clk);
    checkOutput("bp_last_valid", 32'(respValid[0]), 32'd1);
    tick();
    @(negedge clk);
    checkOutput("bp_drop_valid", 32'(respValid[0]), 32'd0);
    checkOutput("bp_accept",     32'(reqReady[0]),  32'd1);
    tick();
    reqValid[0] = 1'b0;
    waitResp(0, d, cyc);
    checkOutput("bp_held_rdata", d, 32'h0);

    // Back-to-back writes then reads of addresses 1..4.
    weBase = weCount;
    prev   = 0;
    for (int i = 1; i <= 4; i++) begin
      issue(0, 1'b1, 10'(i), 32'(i), (i < 4), hs);
      if (i > 1) checkOutput("b2b_wr_spacing", 32'(hs - prev), 32'd2);
      prev = hs;
    end
    tick();
    checkOutput("b2b_we_pulses", 32'(weCount - weBase), 32'd4);
    prev = 0;
    for (int i = 1; i <= 4; i++) begin
      issue(0, 1'b0, 10'(i), 32'h0, 1'b0, u);
      waitResp(0, d, cyc);
      checkOutput("b2b_rd_data", d, 32'(i));
      if (i > 1) checkOutput("b2b_rd_spacing", 32'(cyc - prev), 32'd5);
      prev = cyc;
    end

    // Reset while a read is counting: its response must never appear.
    issue(0, 1'b0, 10'h003, 32'h0, 1'b0, u);
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("midrd_idle_ready", 32'(reqReady[0]), 32'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("midrd_no_resp", 32'(respValid[0]), 32'd0);
      tick();
    end
    issue(0, 1'b0, 10'h002, 32'h0, 1'b0, u);
    waitResp(0, d, cyc);
    checkOutput("midrd_next_data", d, 32'h2);

    // Latency sweep on the latency-1 and latency-7 controllers.
    for (int k = 1; k < 3; k++) begin
      issue(k, 1'b1, 10'h005, 32'hA5A50000 + 32'(k), 1'b0, hs);
      issue(k, 1'b0, 10'h005, 32'h0, 1'b0, u);
      waitResp(k, d, cyc);
      checkOutput("sweep_latency", 32'(cyc - u), (k == 1) ? 32'd3 : 32'd9);
      checkOutput("sweep_data",    d,            32'hA5A50000 + 32'(k));
    end

    applyStimulus(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
